// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter that multiplexes
// I-cache and D-cache line traffic onto one memory port.
package mem_port_arbiter_pkg;

    localparam int ADDR_BITS = 20;
    localparam int LINE_BITS = 128;

    typedef logic [ADDR_BITS-1:0] pptr_t;
    typedef logic [LINE_BITS-1:0] cacheline_t;

    localparam int N_MEM_REQ  = 2;
    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or
// after the pointer, wrapping modulo N.
module mem_port_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  pend_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    // Scan from the far end so the nearest candidate is written last.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (pend_i[j]) begin
                idx_o = IW'(j);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: captures cache-miss pulses into slots,
// issues one transaction at a time, routes responses to owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_MEM_REQ,
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_ren,
    input  logic [N_REQ-1:0]          req_wen,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*LINE_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rec_en,
    output logic [ADDR_W-1:0]         rec_addr,
    output logic [LINE_W-1:0]         rec_cacheline,
    output logic [N_REQ-1:0]          wack,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [LINE_W-1:0]         mem_req_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [LINE_W-1:0]         mem_rsp_data,
    output logic                      busy,
    output logic                      err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_q, rr_d;

    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] we_q, we_d;
    logic [N_REQ-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [N_REQ-1:0][LINE_W-1:0] wdata_q, wdata_d;

    logic              cur_we_q, cur_we_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

    logic [N_REQ-1:0]  rec_en_q, rec_en_d;
    logic [N_REQ-1:0]  wack_q, wack_d;
    logic [ADDR_W-1:0] rec_addr_q, rec_addr_d;
    logic [LINE_W-1:0] rec_line_q, rec_line_d;
    logic              err_q, err_d;

    logic [N_REQ-1:0] clr;
    logic [IW-1:0]    pick;
    logic             any;
    logic             cap_err;
    logic             rsp_err;

    mem_port_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .pend_i (pend_q),
        .ptr_i  (rr_q),
        .idx_o  (pick),
        .any_o  (any)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        clr           = '0;
        cur_we_d      = cur_we_q;
        cur_addr_d    = cur_addr_q;
        rec_en_d      = '0;
        wack_d        = '0;
        rec_addr_d    = rec_addr_q;
        rec_line_d    = rec_line_q;
        rsp_err       = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        unique case (state_q)
            ARB_IDLE: begin
                rsp_err = mem_rsp_valid;
                if (any) begin
                    owner_d = pick;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                rsp_err       = mem_rsp_valid;
                mem_req_valid = 1'b1;
                mem_req_we    = we_q[owner_q];
                mem_req_addr  = addr_q[owner_q];
                mem_req_wdata = wdata_q[owner_q];
                // Keep a private copy so the slot can be refilled now.
                if (mem_req_ready) begin
                    clr[owner_q] = 1'b1;
                    cur_we_d     = we_q[owner_q];
                    cur_addr_d   = addr_q[owner_q];
                    state_d      = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rsp_valid) begin
                    if (cur_we_q) begin
                        wack_d[owner_q] = 1'b1;
                    end else begin
                        rec_en_d[owner_q] = 1'b1;
                        rec_addr_d        = cur_addr_q;
                        rec_line_d        = mem_rsp_data;
                    end
                    rr_d = (owner_q == IW'(N_REQ - 1)) ?
                           '0 : owner_q + 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // A new capture wins over the clear of the same slot.
    always_comb begin
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_err = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (clr[i]) begin
                pend_d[i] = 1'b0;
            end
            if (req_ren[i] && req_wen[i]) begin
                cap_err = 1'b1;
            end else if (req_ren[i] || req_wen[i]) begin
                if (pend_q[i] && !clr[i]) begin
                    cap_err = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    we_d[i]    = req_wen[i];
                    addr_d[i]  = req_addr[i*ADDR_W +: ADDR_W];
                    wdata_d[i] = req_wdata[i*LINE_W +: LINE_W];
                end
            end
        end
        err_d = err_q | cap_err | rsp_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            pend_q     <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cur_we_q   <= 1'b0;
            cur_addr_q <= '0;
            rec_en_q   <= '0;
            wack_q     <= '0;
            rec_addr_q <= '0;
            rec_line_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cur_we_q   <= cur_we_d;
            cur_addr_q <= cur_addr_d;
            rec_en_q   <= rec_en_d;
            wack_q     <= wack_d;
            rec_addr_q <= rec_addr_d;
            rec_line_q <= rec_line_d;
            err_q      <= err_d;
        end
    end

    assign rec_en        = rec_en_q;
    assign wack          = wack_q;
    assign rec_addr      = rec_addr_q;
    assign rec_cacheline = rec_line_q;
    assign err           = err_q;
    assign busy          = (state_q != ARB_IDLE) | (|pend_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for
// single read and contention, hand sequences for the rest.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 20;
    localparam int LW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_ren, req_wen;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_wdata;
    logic [N-1:0]      rec_en, wack;
    pptr_t             rec_addr;
    cacheline_t        rec_cacheline;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    pptr_t             mem_req_addr;
    cacheline_t        mem_req_wdata;
    logic              mem_rsp_valid;
    cacheline_t        mem_rsp_data;
    logic              busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_ren       (req_ren),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rec_en        (rec_en),
        .rec_addr      (rec_addr),
        .rec_cacheline (rec_cacheline),
        .wack          (wack),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy),
        .err           (err)
    );

    typedef struct {
        logic       rst;
        logic [1:0] ren, wen;
        logic [19:0] a0, a1;
        logic [7:0] wd1;
        logic       rdy, rsp;
        logic [7:0] rspb;
        logic       chk;
        logic       v, we;
        logic [19:0] addr;
        logic [7:0] wdb;
        logic [1:0] rec;
        logic [19:0] raddr;
        logic [7:0] lineb;
        logic [1:0] wack;
        logic       busy, err;
    } vec_t;

    vec_t vq[$];

    function automatic void add(
        input logic rst_, input logic [1:0] ren, input logic [1:0] wen,
        input logic [19:0] a0, input logic [19:0] a1, input logic [7:0] wd1,
        input logic rdy, input logic rsp, input logic [7:0] rspb,
        input logic chk_, input logic v, input logic we,
        input logic [19:0] addr, input logic [7:0] wdb,
        input logic [1:0] rec, input logic [19:0] raddr,
        input logic [7:0] lineb, input logic [1:0] wk,
        input logic bsy, input logic er);
        vec_t r;
        r.rst = rst_; r.ren = ren; r.wen = wen; r.a0 = a0; r.a1 = a1;
        r.wd1 = wd1; r.rdy = rdy; r.rsp = rsp; r.rspb = rspb;
        r.chk = chk_; r.v = v; r.we = we; r.addr = addr; r.wdb = wdb;
        r.rec = rec; r.raddr = raddr; r.lineb = lineb; r.wack = wk;
        r.busy = bsy; r.err = er;
        vq.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        req_ren       = '0;
        req_wen       = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic do_reset;
        idle_in;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Simple memory: always ready, answers the cycle after a handshake.
    task automatic run_mem(input int cyc, output int n);
        logic hs;
        n  = 0;
        hs = 1'b0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < cyc; c++) begin
            mem_rsp_valid = hs;
            hs = 1'b0;
            #1;
            if (mem_req_valid) begin
                n++;
                hs = 1'b1;
            end
            tick;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        int n;
        int t;
        int exp_o;
        vec_t r;

        rst = 1'b1;
        idle_in;

        // single read from reset
        add(1,0,0,0,0,0,0,0,0,      0, 0,0,0,0,0,0,0,0,0,0);
        add(0,1,0,'h01234,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,1,0,0,      1, 1,0,'h01234,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,1,0,0,      1, 0,0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,1,0,0,      1, 0,0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,1,'hAA,   1, 0,0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,1,'h01234,'hAA,0,0,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,0,'h01234,'hAA,0,0,0);
        // contention: read on 0, writeback on 1
        add(1,0,0,0,0,0,0,0,0,      0, 0,0,0,0,0,0,0,0,0,0);
        add(0,1,2,'h100,'h200,'h55,0,0,0, 1, 0,0,0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,1,0,0,      1, 1,0,'h100,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,1,'h11,   1, 0,0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,1,'h100,'h11,0,1,0);
        add(0,0,0,0,0,0,1,0,0,      1, 1,1,'h200,'h55,0,'h100,'h11,0,1,0);
        add(0,0,0,0,0,0,0,1,'h99,   1, 0,0,0,0,0,'h100,'h11,0,1,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,0,'h100,'h11,2,0,0);
        add(0,0,0,0,0,0,0,0,0,      1, 0,0,0,0,0,'h100,'h11,0,0,0);

        tick;
        for (int i = 0; i < vq.size(); i++) begin
            r = vq[i];
            rst           = r.rst;
            req_ren       = r.ren;
            req_wen       = r.wen;
            req_addr      = {r.a1, r.a0};
            req_wdata     = {{16{r.wd1}}, 128'h0};
            mem_req_ready = r.rdy;
            mem_rsp_valid = r.rsp;
            mem_rsp_data  = {16{r.rspb}};
            #1;
            if (r.chk) begin
                chk($sformatf("row%0d valid", i), mem_req_valid, r.v);
                chk($sformatf("row%0d we", i), mem_req_we, r.we);
                chk($sformatf("row%0d addr", i), mem_req_addr, r.addr);
                chk($sformatf("row%0d wdata", i), mem_req_wdata,
                    {16{r.wdb}});
                chk($sformatf("row%0d rec_en", i), rec_en, r.rec);
                chk($sformatf("row%0d rec_addr", i), rec_addr, r.raddr);
                chk($sformatf("row%0d line", i), rec_cacheline,
                    {16{r.lineb}});
                chk($sformatf("row%0d wack", i), wack, r.wack);
                chk($sformatf("row%0d busy", i), busy, r.busy);
                chk($sformatf("row%0d err", i), err, r.err);
            end
            tick;
        end
        rst = 1'b0;

        // round-robin with immediate re-requests
        do_reset;
        req_addr = {20'h00020, 20'h00010};
        req_ren  = 2'b11;
        tick;
        req_ren = '0;
        for (int k = 0; k < 6; k++) begin
            exp_o = (k % 2 == 0) ? REQ_ICACHE : REQ_DCACHE;
            t = 0;
            while (!mem_req_valid && t < 20) begin
                tick;
                t++;
            end
            if (!mem_req_valid) begin
                checks++;
                errors++;
                $display("FAIL rr%0d timeout: got no request, required one", k);
            end else begin
                chk($sformatf("rr%0d grant", k), mem_req_addr,
                    (exp_o == REQ_DCACHE) ? 'h20 : 'h10);
                mem_req_ready = 1'b1;
                tick;
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = {16{8'h3C}};
                tick;
                mem_rsp_valid = 1'b0;
                chk($sformatf("rr%0d rec_en", k), rec_en, 1 << exp_o);
                req_ren = 2'(1 << exp_o);
                tick;
                req_ren = '0;
            end
        end
        chk("rr err", err, 0);

        // backpressure on a writeback
        do_reset;
        req_wen   = 2'b10;
        req_addr  = {20'h3ABCD, 20'h0};
        req_wdata = {{16{8'h77}}, 128'h0};
        tick;
        idle_in;
        tick;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d valid", c), mem_req_valid, 1);
            chk($sformatf("bp%0d addr", c), mem_req_addr, 'h3ABCD);
            chk($sformatf("bp%0d we", c), mem_req_we, 1);
            chk($sformatf("bp%0d wdata", c), mem_req_wdata, {16{8'h77}});
            tick;
        end
        mem_req_ready = 1'b1;
        chk("bp hs valid", mem_req_valid, 1);
        tick;
        mem_req_ready = 1'b0;
        chk("bp after hs", mem_req_valid, 0);
        chk("bp busy", busy, 1);
        mem_rsp_valid = 1'b1;
        tick;
        mem_rsp_valid = 1'b0;
        chk("bp wack", wack, 2'b10);
        chk("bp rec_en", rec_en, 0);

        // duplicate request while pending
        do_reset;
        req_ren  = 2'b01;
        req_addr = {20'h0, 20'h00005};
        tick;
        tick;
        idle_in;
        chk("dup err", err, 1);
        run_mem(12, n);
        chk("dup txn count", n, 1);
        chk("dup err hold", err, 1);

        // ren and wen together
        do_reset;
        req_ren = 2'b01;
        req_wen = 2'b01;
        tick;
        idle_in;
        chk("both err", err, 1);
        chk("both busy", busy, 0);
        run_mem(8, n);
        chk("both txn count", n, 0);

        // response while idle
        do_reset;
        mem_rsp_valid = 1'b1;
        tick;
        mem_rsp_valid = 1'b0;
        chk("idle rsp err", err, 1);
        run_mem(8, n);
        chk("idle rsp txn count", n, 0);
        chk("idle rsp err hold", err, 1);
        do_reset;
        chk("err cleared by rst", err, 0);

        // reset while waiting for the response
        do_reset;
        req_ren  = 2'b01;
        req_addr = {20'h0, 20'h00042};
        tick;
        idle_in;
        tick;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        chk("rw in wait", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rw valid", mem_req_valid, 0);
        chk("rw addr", mem_req_addr, 0);
        chk("rw we", mem_req_we, 0);
        chk("rw wdata", mem_req_wdata, 0);
        chk("rw rec_en", rec_en, 0);
        chk("rw rec_addr", rec_addr, 0);
        chk("rw line", rec_cacheline, 0);
        chk("rw wack", wack, 0);
        chk("rw busy", busy, 0);
        chk("rw err", err, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {16{8'hFF}};
        tick;
        mem_rsp_valid = 1'b0;
        chk("stale rec_en", rec_en, 0);
        chk("stale wack", wack, 0);
        chk("stale line", rec_cacheline, 0);
        chk("stale err", err, 1);
        tick;
        chk("stale rec_en late", rec_en, 0);
        chk("stale wack late", wack, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between cache-miss requesters: I-cache = requester 0, D-cache = requester 1.
- Captures each requester's one-cycle request pulse into a per-requester pending slot.
- Grants pending slots round-robin, with one memory transaction outstanding at a time.
- Routes the memory response (line refill or write ack) back to the owning requester only.
- Sits between the IF/MEM-stage caches and the memory model.

Parameters:
- N_REQ, 2, number of requesters (index 0 = I-cache, 1 = D-cache).
- ADDR_W, 20, physical address width (matches pptr_t).
- LINE_W, 128, cacheline width in bits (matches cacheline_t).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_ren  in  N_REQ  per-requester read request pulse
- req_wen  in  N_REQ  per-requester writeback request pulse
- req_addr  in  N_REQ*ADDR_W  packed per-requester line address
- req_wdata  in  N_REQ*LINE_W  packed per-requester writeback line
- rec_en  out  N_REQ  one-hot read-response pulse to the owner
- rec_addr  out  ADDR_W  address of the returned line (shared bus)
- rec_cacheline  out  LINE_W  returned line data (shared bus)
- wack  out  N_REQ  one-hot write-acknowledge pulse
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_W  memory address
- mem_req_wdata  out  LINE_W  write data
- mem_rsp_valid  in  1  memory response or ack, one-cycle pulse
- mem_rsp_data  in  LINE_W  read data
- busy  out  1  state != IDLE or any slot pending
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: every output is 0, all pending slots are cleared, rr_ptr = 0, state = IDLE. Reset mid-transaction abandons the transaction; no rec_en or wack is emitted for it.
- Capture:
  - A pulse req_ren[i] or req_wen[i] at cycle t sets pending[i] at t+1, storing addr, we and wdata.
  - ren and wen both high in the same cycle: the request is ignored and err is set.
  - A pulse while pending[i] is already set: the new request is dropped and err is set.
  - The set of a slot has priority over the same-cycle clear of that slot, so a requester may re-request in the same cycle its slot is handed to memory.
- States IDLE, ISSUE, WAIT:
  - IDLE: if any slot is pending, pick the first pending index scanning from rr_ptr upward (mod N_REQ). Latch it as owner and go to ISSUE.
  - ISSUE: mem_req_valid = 1, with we, addr and wdata taken from pending[owner]. On mem_req_valid & mem_req_ready: clear pending[owner] and go to WAIT. Outputs hold stable while ready is low.
  - WAIT: on mem_rsp_valid:
    - Read: rec_en[owner] = 1, rec_addr = the owner's latched addr, rec_cacheline = mem_rsp_data.
    - Write: wack[owner] = 1.
    - In both cases rr_ptr = (owner+1) mod N_REQ and the state returns to IDLE.
- Output timing: rec_en, wack, rec_addr and rec_cacheline are registered and visible at cycle r+1 for a response at cycle r. rec_en and wack are 1-cycle pulses. rec_addr and rec_cacheline hold their last value otherwise.
- Minimum latency: a request pulse at t gives mem_req_valid at t+2. With ready=1 at t+2 the state is WAIT at t+3. A response at r gives the owner pulse at r+1, and the next grant's mem_req_valid at r+2.
- mem_rsp_valid in IDLE or ISSUE: ignored, err is set.
- Fairness: a continuously re-requesting requester cannot take two consecutive grants while another slot is pending.
- err clears only on rst.

Decomposition:
- Shared common package:
  - pptr_t, cacheline_t
  - N_MEM_REQ = 2
  - REQ_ICACHE = 0, REQ_DCACHE = 1
  - enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
- One natural sub-module: rr_pick, a combinational round-robin picker. Inputs: pending vector and rr_ptr. Outputs: grant index and any_valid.

Test Plan:
- Single read: req_ren[0] with addr 0x01234 at t, ready=1, response 0xAA..AA three cycles after issue.
  - Expect mem_req_valid at t+2 with we=0 and addr 0x01234.
  - Expect rec_en = 2'b01 for one cycle, rec_addr = 0x01234, line = 0xAA..AA.
  - wack stays 0.
- Contention: req_ren[0] (addr 0x100) and req_wen[1] (addr 0x200) in the same cycle, rr_ptr = 0.
  - Expect requester 0 to issue first; after its rec_en, requester 1 issues with we=1 and addr 0x200.
  - Expect wack = 2'b10 after its response.
- Round-robin: both requesters re-pulse immediately after each completion, for 6 transactions.
  - Expect grant order 0,1,0,1,0,1.
- Backpressure: mem_req_ready held low 5 cycles during ISSUE.
  - Expect mem_req_valid, addr and we stable for all 5 cycles; the handshake occurs on the first ready=1 cycle.
- Protocol errors, each from reset: (a) a duplicate req_ren[0] while pending[0] is set; (b) ren and wen both high together; (c) mem_rsp_valid while IDLE.
  - Expect err = 1 in each case, persisting until rst.
  - Expect no extra transaction on the memory port.
- Reset in WAIT: assert rst for 1 cycle mid-transaction, then pulse mem_rsp_valid.
  - Expect all outputs 0 after reset and no rec_en or wack for the abandoned transaction.
  - Expect the stale response to set err.
